// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
//   Shared SHA-256 constants and helpers for the schedule controller:
//   - ROUNDS / WORD_W / BLOCK_W sizing constants
//   - state_t : controller state encoding
//   - k_const : round constant K[t] (64-entry ROM)
//   - iv_word : initial hash value H0..H7
//   - s0 / s1 : message-schedule small sigma functions
// -----------------------------------------------------------------------------
package sha256_pkg;

  localparam int ROUNDS    = 64;
  localparam int WORD_W    = 32;
  localparam int WIN_DEPTH = 16;
  localparam int BLOCK_W   = WORD_W * WIN_DEPTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // sigma0: ror7 ^ ror18 ^ shr3
  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // sigma1: ror17 ^ ror19 ^ shr10
  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Initial hash value; the datapath loads it on o_init_hash.
  function automatic logic [31:0] iv_word(input logic [2:0] idx);
    logic [31:0] h;
    h = '0;
    case (idx)
      3'd0: h = 32'h6a09e667;
      3'd1: h = 32'hbb67ae85;
      3'd2: h = 32'h3c6ef372;
      3'd3: h = 32'ha54ff53a;
      3'd4: h = 32'h510e527f;
      3'd5: h = 32'h9b05688c;
      3'd6: h = 32'h1f83d9ab;
      3'd7: h = 32'h5be0cd19;
    endcase
    return h;
  endfunction

  // Round constants K[0..63].
  function automatic logic [31:0] k_const(input logic [5:0] t);
    logic [31:0] k;
    k = '0;
    case (t)
      6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;
      6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;
      6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;
      6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;
      6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;
      6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;
      6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;
      6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;
      6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;
      6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;
      6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;
      6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;
      6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;
      6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;
      6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;
      6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;
      6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/sha256_w_window.sv
// -----------------------------------------------------------------------------
// sha256_w_window
//   16-word message-schedule window. win[0] always holds W_t for the current
//   round; each shift drops W_t and appends the freshly expanded W_{t+16}.
// Ports
//   i_clk        clock, rising edge
//   i_reset      asynchronous, active-low reset
//   i_load       load M0..M15 from i_load_data (M0 at the top bits)
//   i_shift      advance one round
//   i_load_data  512-bit message block
//   o_w          current schedule word W_t (win[0])
// -----------------------------------------------------------------------------
module sha256_w_window
  import sha256_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic [BLOCK_W-1:0] i_load_data,
  output logic [WORD_W-1:0]  o_w
);

  logic [WORD_W-1:0] win [WIN_DEPTH];
  logic [WORD_W-1:0] w_next;

  // W_{t+16} = s1(W_{t+14}) + W_{t+9} + s0(W_{t+1}) + W_t, mod 2^32.
  // Past round 47 the result is never consumed; computing it is harmless.
  assign w_next = s1(win[14]) + win[9] + s0(win[1]) + win[0];

  // NOTE: the window is reset even though it is plain storage, so W_t is
  // defined (zero) straight out of reset rather than left as power-up junk.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < WIN_DEPTH; i++) win[i] <= '0;
    end else if (i_load) begin
      for (int i = 0; i < WIN_DEPTH; i++)
        win[i] <= i_load_data[BLOCK_W-1-WORD_W*i -: WORD_W];
    end else if (i_shift) begin
      // NOTE: non-blocking assignments make every word take its neighbour's
      // old value, so the shift order inside the loop does not matter.
      for (int i = 0; i < WIN_DEPTH-1; i++) win[i] <= win[i+1];
      win[WIN_DEPTH-1] <= w_next;
    end
  end

  assign o_w = win[0];

endmodule

// File: rtl/sha256_sched_ctrl.sv
// -----------------------------------------------------------------------------
// sha256_sched_ctrl
//   Sequences one SHA-256 compression per 512-bit block: accepts a block from
//   the padder, streams W_t/K_t for rounds 0..63 to the round datapath with a
//   valid/ready handshake, and pulses init-hash / fold / digest strobes.
// Ports
//   i_clk, i_reset                clock, async active-low reset
//   i_blk_valid/first/last        block offer and message position flags
//   i_block                       M0 at [511:480] .. M15 at [31:0]
//   o_blk_ready                   controller idle, can take a block
//   o_rnd_valid, i_rnd_ready      round handshake
//   o_rnd_idx, o_w, o_k           round index t, W_t, K_t
//   o_init_hash                   pulse: datapath loads IV (first block only)
//   o_fold                        pulse: H += a..h after round 63
//   o_digest_valid                pulse: H holds the final digest (last block)
//   o_busy                        controller not idle
// -----------------------------------------------------------------------------
module sha256_sched_ctrl
  import sha256_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_blk_valid,
  input  logic         i_blk_first,
  input  logic         i_blk_last,
  input  logic [511:0] i_block,
  output logic         o_blk_ready,
  output logic         o_rnd_valid,
  input  logic         i_rnd_ready,
  output logic [5:0]   o_rnd_idx,
  output logic [31:0]  o_w,
  output logic [31:0]  o_k,
  output logic         o_init_hash,
  output logic         o_fold,
  output logic         o_digest_valid,
  output logic         o_busy
);

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  state_t            state;
  logic [5:0]        t;
  logic              last_q;
  logic              accept;
  logic              fire;
  logic [WORD_W-1:0] win_w;

  // o_blk_ready is high exactly in IDLE, so an offer elsewhere is ignored
  // and stays pending at the padder.
  assign accept = i_blk_valid & o_blk_ready;
  assign fire   = o_rnd_valid & i_rnd_ready;

  sha256_w_window u_window (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (accept),
    .i_shift     (fire),
    .i_load_data (i_block),
    .o_w         (win_w)
  );

  // W/K are only meaningful with o_rnd_valid; zero them otherwise so the
  // idle bus is quiet and K[0] does not show up out of reset.
  assign o_w       = o_rnd_valid ? win_w      : '0;
  assign o_k       = o_rnd_valid ? k_const(t) : '0;
  assign o_rnd_idx = t;

  // Single FSM block; every strobe is a register so the datapath sees
  // glitch-free, edge-aligned controls.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state          <= ST_IDLE;
      t              <= '0;
      last_q         <= 1'b0;
      o_blk_ready    <= 1'b1;
      o_rnd_valid    <= 1'b0;
      o_init_hash    <= 1'b0;
      o_fold         <= 1'b0;
      o_digest_valid <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      o_init_hash    <= 1'b0;
      o_fold         <= 1'b0;
      o_digest_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            state       <= ST_RUN;
            t           <= '0;
            last_q      <= i_blk_last;
            o_init_hash <= i_blk_first;
            o_blk_ready <= 1'b0;
            o_rnd_valid <= 1'b1;
            o_busy      <= 1'b1;
          end
        end

        ST_RUN: begin
          if (fire) begin
            if (t == LAST_ROUND) begin
              // t parks at 63; it is cleared on the next accept.
              state       <= ST_FOLD;
              o_rnd_valid <= 1'b0;
              o_fold      <= 1'b1;
            end else begin
              t <= t + 6'd1;
            end
          end
        end

        ST_FOLD: begin
          if (last_q) begin
            state          <= ST_DONE;
            o_digest_valid <= 1'b1;
          end else begin
            state       <= ST_IDLE;
            o_blk_ready <= 1'b1;
            o_busy      <= 1'b0;
          end
        end

        ST_DONE: begin
          state       <= ST_IDLE;
          o_blk_ready <= 1'b1;
          o_busy      <= 1'b0;
        end

        default: begin
          state       <= ST_IDLE;
          o_blk_ready <= 1'b1;
          o_rnd_valid <= 1'b0;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sha256_sched_ctrl
//   Self-checking bench for sha256_sched_ctrl. A reference schedule model
//   fills a scoreboard with the 64 expected {t, W_t, K_t} records when a
//   block is accepted; each round fire pops and compares one record.
//   Checkpoint vectors for the "abc" block are held in a small table.
// -----------------------------------------------------------------------------
module tb_sha256_sched_ctrl;

  logic         i_clk;
  logic         i_reset;
  logic         i_blk_valid;
  logic         i_blk_first;
  logic         i_blk_last;
  logic [511:0] i_block;
  logic         o_blk_ready;
  logic         o_rnd_valid;
  logic         i_rnd_ready;
  logic [5:0]   o_rnd_idx;
  logic [31:0]  o_w;
  logic [31:0]  o_k;
  logic         o_init_hash;
  logic         o_fold;
  logic         o_digest_valid;
  logic         o_busy;

  sha256_sched_ctrl dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_blk_valid    (i_blk_valid),
    .i_blk_first    (i_blk_first),
    .i_blk_last     (i_blk_last),
    .i_block        (i_block),
    .o_blk_ready    (o_blk_ready),
    .o_rnd_valid    (o_rnd_valid),
    .i_rnd_ready    (i_rnd_ready),
    .o_rnd_idx      (o_rnd_idx),
    .o_w            (o_w),
    .o_k            (o_k),
    .o_init_hash    (o_init_hash),
    .o_fold         (o_fold),
    .o_digest_valid (o_digest_valid),
    .o_busy         (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] w;
    logic [31:0] k;
  } rnd_t;

  typedef struct packed {
    logic [5:0]  t;
    logic [31:0] w;
    logic [31:0] k;
  } vec_t;

  localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [75:0]  RST_EXP   = {1'b1, 75'd0};

  logic [31:0] ktab [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          fires = 0;
  int          init_cnt = 0, fold_cnt = 0, digest_cnt = 0;
  int          init_cyc = 0, fold_cyc = 0, digest_cyc = 0, acc_cyc = 0;
  bit          acc_flag = 0;
  bit          stalled_prev = 0;
  logic [69:0] prev_out;
  logic [31:0] exp_w [0:63];
  logic [31:0] obs_w [0:63];
  logic [31:0] obs_k [0:63];
  rnd_t        exp_q [$];
  vec_t        vecs [5];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule written in the textbook W[t-2]/W[t-7]/W[t-15]/W[t-16] form.
  task automatic make_sched(input logic [511:0] blk);
    logic [31:0] a, b;
    for (int t = 0; t < 16; t++) exp_w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      a = ror(exp_w[t-2], 17) ^ ror(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
      b = ror(exp_w[t-15], 7) ^ ror(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
      exp_w[t] = a + exp_w[t-7] + b + exp_w[t-16];
    end
  endtask

  function automatic logic [75:0] pack_out();
    return {o_blk_ready, o_rnd_valid, o_init_hash, o_fold, o_digest_valid, o_busy,
            o_rnd_idx, o_w, o_k};
  endfunction

  // Observe the current cycle (scoreboard, stall stability, strobes), then
  // advance to 1 time unit after the next rising edge.
  task automatic tick();
    logic [69:0] cur;
    rnd_t        r;
    cur = {o_rnd_idx, o_w, o_k};
    if (stalled_prev) check("stall_hold", {o_rnd_valid, cur}, {1'b1, prev_out});
    if (i_reset && i_blk_valid && o_blk_ready) begin
      make_sched(i_block);
      for (int t = 0; t < 64; t++) exp_q.push_back('{idx: 6'(t), w: exp_w[t], k: ktab[t]});
      acc_cyc  = cyc;
      acc_flag = 1;
      fires    = 0;
    end
    if (o_rnd_valid && i_rnd_ready) begin
      fires++;
      if (exp_q.size() == 0) fail("unexpected_round_fire");
      else begin
        r = exp_q.pop_front();
        check("rnd_idx", o_rnd_idx, r.idx);
        check("rnd_w", o_w, r.w);
        check("rnd_k", o_k, r.k);
        obs_w[o_rnd_idx] = o_w;
        obs_k[o_rnd_idx] = o_k;
      end
    end
    if (o_init_hash) begin init_cnt++; init_cyc = cyc; end
    if (o_fold) begin
      fold_cnt++;
      fold_cyc = cyc;
      check("fires_before_fold", fires, 64);
    end
    if (o_digest_valid) begin digest_cnt++; digest_cyc = cyc; end
    stalled_prev = o_rnd_valid && !i_rnd_ready;
    prev_out     = cur;
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  // Offer a block, run it to completion and check strobe counts/latencies.
  task automatic run_block(input logic [511:0] blk, input logic first, input logic last,
                           input bit stall);
    int n, i0, f0, d0;
    i0 = init_cnt; f0 = fold_cnt; d0 = digest_cnt;
    i_block = blk; i_blk_first = first; i_blk_last = last; i_blk_valid = 1'b1;
    acc_flag = 0;
    n = 0;
    while (!acc_flag && n < 50) begin
      i_rnd_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    i_blk_valid = 1'b0;
    if (!acc_flag) fail("accept_timeout");
    n = 0;
    while (!o_blk_ready && n < 1000) begin
      i_rnd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    if (!o_blk_ready) fail("block_timeout");
    check("init_count", init_cnt - i0, first);
    check("fold_count", fold_cnt - f0, 1);
    check("digest_count", digest_cnt - d0, last);
    check("sb_drained", exp_q.size(), 0);
    if (!stall) begin
      if (first) check("init_cyc", init_cyc, acc_cyc + 1);
      check("fold_cyc", fold_cyc, acc_cyc + 65);
      if (last) check("digest_cyc", digest_cyc, acc_cyc + 66);
      check("ready_again_cyc", cyc, acc_cyc + 66 + int'(last));
    end
  endtask

  initial begin
    logic [511:0] blk_b;
    int n, acc_a, f0, d0, i0;

    i_reset = 1'b0; i_blk_valid = 1'b0; i_blk_first = 1'b0; i_blk_last = 1'b0;
    i_block = '0;   i_rnd_ready = 1'b0;

    vecs[0] = '{t: 6'd0,  w: 32'h61626380, k: 32'h428a2f98};
    vecs[1] = '{t: 6'd15, w: 32'h00000018, k: 32'hc19bf174};
    vecs[2] = '{t: 6'd16, w: 32'h61626380, k: 32'he49b69c1};
    vecs[3] = '{t: 6'd17, w: 32'h000f0000, k: 32'hefbe4786};
    vecs[4] = '{t: 6'd63, w: 32'h12b1edeb, k: 32'hc67178f2};

    // Reset held with random inputs, then released with no offer.
    for (int i = 0; i < 6; i++) begin
      i_blk_valid = 1'($urandom_range(0, 1));
      i_blk_first = 1'($urandom_range(0, 1));
      i_blk_last  = 1'($urandom_range(0, 1));
      i_rnd_ready = 1'($urandom_range(0, 1));
      for (int j = 0; j < 16; j++) i_block[32*j +: 32] = $urandom;
      tick();
      check("reset_state", pack_out(), RST_EXP);
    end
    i_blk_valid = 1'b0;
    i_reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_rnd_ready = 1'($urandom_range(0, 1));
      tick();
      check("idle_after_release", pack_out(), RST_EXP);
    end

    // "abc" single-block message, no stalls, then checkpoint table.
    run_block(ABC_BLOCK, 1'b1, 1'b1, 1'b0);
    foreach (vecs[i]) begin
      check("abc_vec_w", obs_w[vecs[i].t], vecs[i].w);
      check("abc_vec_k", obs_k[vecs[i].t], vecs[i].k);
    end

    // Same block with ~50% random round stalls.
    run_block(ABC_BLOCK, 1'b1, 1'b1, 1'b1);

    // Two-block message.
    for (int j = 0; j < 16; j++) blk_b[32*j +: 32] = $urandom;
    run_block(ABC_BLOCK, 1'b1, 1'b0, 1'b0);
    run_block(blk_b, 1'b0, 1'b1, 1'b0);

    // Offer held during RUN must wait for IDLE and be taken as ready rises.
    i0 = init_cnt; f0 = fold_cnt; d0 = digest_cnt;
    i_block = ABC_BLOCK; i_blk_first = 1'b1; i_blk_last = 1'b0; i_blk_valid = 1'b1;
    i_rnd_ready = 1'b1;
    acc_flag = 0; n = 0;
    while (!acc_flag && n < 50) begin tick(); n++; end
    if (!acc_flag) fail("held_first_accept_timeout");
    acc_a = acc_cyc;
    i_blk_valid = 1'b0;
    repeat (10) tick();
    i_block = blk_b; i_blk_first = 1'b0; i_blk_last = 1'b1; i_blk_valid = 1'b1;
    acc_flag = 0; n = 0;
    while (!acc_flag && n < 200) begin tick(); n++; end
    if (!acc_flag) fail("held_offer_accept_timeout");
    i_blk_valid = 1'b0;
    check("held_offer_accept_cyc", acc_cyc, acc_a + 66);
    n = 0;
    while (!o_blk_ready && n < 200) begin tick(); n++; end
    check("held_init_count", init_cnt - i0, 1);
    check("held_fold_count", fold_cnt - f0, 2);
    check("held_digest_count", digest_cnt - d0, 1);
    check("held_sb_drained", exp_q.size(), 0);

    // Asynchronous reset at t=30 aborts the block.
    i_block = ABC_BLOCK; i_blk_first = 1'b1; i_blk_last = 1'b1; i_blk_valid = 1'b1;
    acc_flag = 0; n = 0;
    while (!acc_flag && n < 50) begin tick(); n++; end
    i_blk_valid = 1'b0;
    n = 0;
    while (!(o_rnd_valid && o_rnd_idx == 6'd30) && n < 100) begin tick(); n++; end
    if (!(o_rnd_valid && o_rnd_idx == 6'd30)) fail("reach_t30_timeout");
    #2;
    i_reset = 1'b0;
    #1;
    check("async_reset_abort", pack_out(), RST_EXP);
    exp_q.delete();
    stalled_prev = 0;
    f0 = fold_cnt; d0 = digest_cnt;
    repeat (3) tick();
    i_reset = 1'b1;
    for (int i = 0; i < 80; i++) begin
      i_rnd_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("abort_no_fold", fold_cnt - f0, 0);
    check("abort_no_digest", digest_cnt - d0, 0);
    check("abort_idle", pack_out(), RST_EXP);
    run_block(ABC_BLOCK, 1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
